// File: rtl/mmio_bus_bridge_if.sv
// ---------------------------------------------------------------------------
// mmio_bus_bridge_if
//
// Purpose : Bundles the processor strobe bus and the MMIO-side bus seen by
//           mmio_bus_bridge, so the bridge has one bus port plus clk/reset.
//
// Signals (direction as seen by the bridge, modport "slave"):
//   io_addr_strobe  in   1   processor request valid, single-cycle pulse
//   io_read_strobe  in   1   read request, qualified by io_addr_strobe
//   io_write_strobe in   1   write request, qualified by io_addr_strobe
//   io_address      in  32   byte address
//   io_write_data   in  32   write data
//   io_read_data    out 32   read data, valid only with io_ready
//   io_ready        out  1   access-complete pulse
//   io_bus_err      out  1   error flag, pulses with io_ready
//   mmio_cs         out  1   MMIO access select
//   mmio_wr         out  1   MMIO write pulse
//   mmio_rd         out  1   MMIO read pulse
//   mmio_addr       out 21   word address (io_address[22:2])
//   mmio_wr_data    out 32   registered write data
//   mmio_rd_data    in  32   MMIO read data from the controller
//
// Modports: slave  = the bridge
//           master = the environment (processor + MMIO controller)
// ---------------------------------------------------------------------------
interface mmio_bus_bridge_if;
    logic        io_addr_strobe;
    logic        io_read_strobe;
    logic        io_write_strobe;
    logic [31:0] io_address;
    logic [31:0] io_write_data;
    logic [31:0] io_read_data;
    logic        io_ready;
    logic        io_bus_err;
    logic        mmio_cs;
    logic        mmio_wr;
    logic        mmio_rd;
    logic [20:0] mmio_addr;
    logic [31:0] mmio_wr_data;
    logic [31:0] mmio_rd_data;

    modport slave (
        input  io_addr_strobe, io_read_strobe, io_write_strobe,
        input  io_address, io_write_data, mmio_rd_data,
        output io_read_data, io_ready, io_bus_err,
        output mmio_cs, mmio_wr, mmio_rd, mmio_addr, mmio_wr_data
    );

    modport master (
        output io_addr_strobe, io_read_strobe, io_write_strobe,
        output io_address, io_write_data, mmio_rd_data,
        input  io_read_data, io_ready, io_bus_err,
        input  mmio_cs, mmio_wr, mmio_rd, mmio_addr, mmio_wr_data
    );
endinterface

// File: rtl/mmio_bus_bridge.sv
// ---------------------------------------------------------------------------
// mmio_bus_bridge
//
// Purpose : Converts the processor's strobe-based IO bus into single-cycle
//           mmio_cs/mmio_wr/mmio_rd accesses. Decodes the bridge region,
//           sequences each access through a small FSM with an optional read
//           wait, and answers with io_ready (plus io_bus_err for accesses
//           outside the region or with malformed strobes).
//
// Ports:
//   clk    in   system clock
//   reset  in   asynchronous active-low reset (0 = reset)
//   bus    slave modport of mmio_bus_bridge_if (processor + MMIO buses)
//
// Parameters:
//   BRIDGE_BASE  region base; io_address[31:24] must match BRIDGE_BASE[31:24]
//                and io_address[23] must be 0
//   RD_WAIT      extra cycles between mmio_rd and read-data capture (0..7)
//   ERR_DATA     read data returned with an error response
//
// Configuration macro:
//   MMIO_BRIDGE_POSTED_WR_EN  when defined, hit writes acknowledge in the
//                             same cycle as mmio_wr and skip RESP.
// ---------------------------------------------------------------------------
module mmio_bus_bridge #(
    parameter logic [31:0] BRIDGE_BASE = 32'hC000_0000,
    parameter int          RD_WAIT     = 0,
    parameter logic [31:0] ERR_DATA    = 32'hDEAD_BEEF
) (
    input  logic               clk,
    input  logic               reset,
    mmio_bus_bridge_if.slave   bus
);

    typedef enum logic [2:0] {
        IDLE,
        WR,
        RD,
        RWAIT,
        RESP,
        ERR
    } state_t;

    state_t     state;
    logic [2:0] wait_cnt;   // RWAIT cycles still to go after the current one

    logic hit;
    logic strobe_bad;

    assign hit        = (bus.io_address[31:24] == BRIDGE_BASE[31:24]) && !bus.io_address[23];
    assign strobe_bad = (bus.io_read_strobe == bus.io_write_strobe);

    // Byte-lane bits are not part of the word address.
    logic unused_byte_bits;
    assign unused_byte_bits = ^bus.io_address[1:0];

    // All outputs are registered: each state's outputs are loaded on the
    // transition into that state, so the output registers always describe
    // the state currently held.
    // NOTE: every register (including the held address/data) is cleared by
    // the asynchronous reset, so outputs are 0 the moment reset asserts and
    // a pending mmio_rd/mmio_wr is dropped without waiting for a clock.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state            <= IDLE;
            wait_cnt         <= '0;
            bus.io_read_data <= '0;
            bus.io_ready     <= 1'b0;
            bus.io_bus_err   <= 1'b0;
            bus.mmio_cs      <= 1'b0;
            bus.mmio_wr      <= 1'b0;
            bus.mmio_rd      <= 1'b0;
            bus.mmio_addr    <= '0;
            bus.mmio_wr_data <= '0;
        end else begin
            // NOTE: non-blocking defaults first; the case below overrides
            // only what the next state drives, so pulses last one cycle.
            bus.io_read_data <= '0;
            bus.io_ready     <= 1'b0;
            bus.io_bus_err   <= 1'b0;
            bus.mmio_cs      <= 1'b0;
            bus.mmio_wr      <= 1'b0;
            bus.mmio_rd      <= 1'b0;

            case (state)
                IDLE: begin
                    if (bus.io_addr_strobe) begin
                        bus.mmio_addr    <= bus.io_address[22:2];
                        bus.mmio_wr_data <= bus.io_write_data;
                        if (strobe_bad || !hit) begin
                            state            <= ERR;
                            bus.io_ready     <= 1'b1;
                            bus.io_bus_err   <= 1'b1;
                            bus.io_read_data <= ERR_DATA;
                        end else if (bus.io_write_strobe) begin
                            state       <= WR;
                            bus.mmio_cs <= 1'b1;
                            bus.mmio_wr <= 1'b1;
`ifdef MMIO_BRIDGE_POSTED_WR_EN
                            bus.io_ready <= 1'b1;
`endif
                        end else begin
                            state       <= RD;
                            bus.mmio_cs <= 1'b1;
                            bus.mmio_rd <= 1'b1;
                        end
                    end
                end

                WR: begin
`ifdef MMIO_BRIDGE_POSTED_WR_EN
                    // Already acknowledged alongside mmio_wr.
                    state <= IDLE;
`else
                    state        <= RESP;
                    bus.io_ready <= 1'b1;
`endif
                end

                RD: begin
                    if (RD_WAIT == 0) begin
                        state            <= RESP;
                        bus.io_ready     <= 1'b1;
                        bus.io_read_data <= bus.mmio_rd_data;
                    end else begin
                        state       <= RWAIT;
                        bus.mmio_cs <= 1'b1;
                        wait_cnt    <= 3'(RD_WAIT - 1);
                    end
                end

                RWAIT: begin
                    if (wait_cnt == 3'd0) begin
                        // Final wait cycle: read data is captured here.
                        state            <= RESP;
                        bus.io_ready     <= 1'b1;
                        bus.io_read_data <= bus.mmio_rd_data;
                    end else begin
                        bus.mmio_cs <= 1'b1;
                        wait_cnt    <= wait_cnt - 3'd1;
                    end
                end

                RESP:    state <= IDLE;
                ERR:     state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/mmio_bus_bridge.md
Name: mmio_bus_bridge

Overview:
Upstream stage of the MMIO subsystem. Converts the processor's strobe-based IO bus into the single-cycle mmio_cs/mmio_wr/mmio_rd bus consumed by the MMIO controller and its slots. The block decodes the MMIO region, sequences each access through a small FSM with a configurable read wait, and returns io_ready with the read data. Out-of-region accesses complete locally with an error response.

Parameters:
BRIDGE_BASE, 32'hC000_0000, base of bridge space; io_address[31:24] must equal BRIDGE_BASE[31:24].
RD_WAIT, 0, extra cycles between the mmio_rd pulse and read-data capture; legal range 0..7.
ERR_DATA, 32'hDEAD_BEEF, read data returned on a decode or protocol error.

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-low reset (0 = reset)
io_addr_strobe  in  1  processor request valid, single-cycle pulse
io_read_strobe  in  1  read request, qualified by io_addr_strobe
io_write_strobe  in  1  write request, qualified by io_addr_strobe
io_address  in  32  byte address
io_write_data  in  32  write data
io_read_data  out  32  read data, valid only when io_ready=1
io_ready  out  1  access-complete pulse, one cycle
io_bus_err  out  1  error flag, pulses together with io_ready
mmio_cs  out  1  MMIO access select
mmio_wr  out  1  MMIO write pulse
mmio_rd  out  1  MMIO read pulse
mmio_addr  out  21  word address = io_address[22:2]
mmio_wr_data  out  32  registered write data
mmio_rd_data  in  32  MMIO read data, combinational from the controller

Behaviour:
- All outputs are registered. While reset=0, every output is 0 and the FSM is in IDLE. Assertion is asynchronous; release is synchronous.
- FSM states: IDLE, WR, RD, RWAIT, RESP, ERR.
- IDLE: on io_addr_strobe=1, latch address, data and type.
  - hit = (io_address[31:24]==BRIDGE_BASE[31:24]) and io_address[23]==0.
  - Read and write strobes both 1, or both 0: go to ERR.
  - Miss: go to ERR.
  - Hit write: go to WR. Hit read: go to RD.
- WR (1 cycle): mmio_cs=1, mmio_wr=1, mmio_addr and mmio_wr_data hold the latched values. Next state is RESP.
- RD (1 cycle): mmio_cs=1, mmio_rd=1.
  - RD_WAIT=0: capture mmio_rd_data this cycle, go to RESP.
  - Otherwise go to RWAIT.
- RWAIT: mmio_cs=1, mmio_rd=0, mmio_addr held. A 3-bit counter counts RD_WAIT cycles. Capture mmio_rd_data in the final RWAIT cycle, then go to RESP.
- mmio_rd is a single-cycle pulse per access, so read-to-pop slots such as the UART pop exactly once.
- RESP (1 cycle): io_ready=1, io_bus_err=0. io_read_data = captured data for a read, 0 for a write. Next state is IDLE.
- ERR (1 cycle): io_ready=1, io_bus_err=1, io_read_data=ERR_DATA. No mmio_cs/wr/rd activity. Next state is IDLE.
- Latency (strobe in cycle T):
  - write: mmio_wr at T+1, io_ready at T+2.
  - read: mmio_rd at T+1, io_ready at T+2+RD_WAIT.
  - error: io_ready at T+1.
- io_read_data returns to 0 in the cycle after io_ready.
- mmio_addr and mmio_wr_data hold their last values in IDLE. mmio_cs, mmio_wr and mmio_rd are 0 in IDLE.
- A strobe in any state other than IDLE is ignored: no latch, no downstream access. The processor protocol forbids it; the bench asserts it has no effect.
- A new strobe in the same cycle as io_ready is ignored. A strobe in the cycle after io_ready is accepted.
- Reset mid-access aborts the access. No io_ready is issued, and any pending mmio_rd/mmio_wr is dropped immediately.

Optional Feature:
MMIO_BRIDGE_POSTED_WR_EN
- Defined: hit writes are posted. io_ready=1 in WR together with mmio_wr, at T+1. RESP is skipped and WR returns to IDLE. Reads and errors are unchanged.
- Undefined: writes acknowledge in RESP at T+2, as described above.

Test Plan:
- Write hit: strobe write, io_address=0xC000_0088, data=0x0000_0055.
  -> T+1: mmio_cs=1, mmio_wr=1, mmio_addr=0x22, mmio_wr_data=0x55.
  -> T+2: io_ready=1, io_bus_err=0. With MMIO_BRIDGE_POSTED_WR_EN: io_ready at T+1.
- Read hit, RD_WAIT=0: io_address=0xC000_0060, mmio_rd_data=0x1234_5678.
  -> mmio_rd one cycle at T+1.
  -> T+2: io_ready=1, io_read_data=0x1234_5678.
- Read hit, RD_WAIT=3: mmio_rd_data changes to 0xA5A5_0001 only in cycle T+4.
  -> mmio_rd single pulse at T+1; mmio_cs high T+1..T+4.
  -> T+5: io_ready=1, io_read_data=0xA5A5_0001.
- Miss (0x8000_0000) and address-bit-23 access (0xC080_0000):
  -> T+1: io_ready=1, io_bus_err=1, io_read_data=0xDEAD_BEEF.
  -> mmio_cs stays 0 throughout.
- Both read and write strobes set: ERR response at T+1. A second strobe issued during RWAIT: ignored, and exactly one mmio_rd pulse is seen.
- reset=0 during RWAIT: all outputs 0 immediately; no io_ready after release; the next read completes normally.
